// File: rtl/dmg_timer_pkg.sv
// Shared constants and enums for the DMG programmable timer (TIMA/TMA/TAC).
package dmg_timer_pkg;
  localparam logic [1:0] A_TIMA = 2'd1;
  localparam logic [1:0] A_TMA  = 2'd2;
  localparam logic [1:0] A_TAC  = 2'd3;

  typedef enum logic [1:0] {
    TAP_4K   = 2'b00,
    TAP_262K = 2'b01,
    TAP_65K  = 2'b10,
    TAP_16K  = 2'b11
  } tap_sel_e;

  typedef enum logic [1:0] {RUN, OVF, RELOAD} state_e;
endpackage

// File: rtl/dmg_timer_if.sv
// CPU register bus slice for FF04-FF07; the timer is the slave.
interface dmg_timer_if;
  logic       sel;
  logic [1:0] addr;
  logic       cpu_wr;
  logic       cpu_rd;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (output sel, addr, cpu_wr, cpu_rd, d_in, input d_out, d_oe);
  modport slave  (input sel, addr, cpu_wr, cpu_rd, d_in, output d_out, d_oe);
endinterface

// File: rtl/dmg_timer_tap.sv
// Divider tap mux, enable gate and falling-edge detector producing the TIMA inc pulse.
module dmg_timer_tap
  import dmg_timer_pkg::*;
(
  input  logic       clk,
  input  logic       nreset,
  input  logic [9:0] div,
  input  logic [2:0] tac,
  input  logic       mask,
  output logic       inc
);
  logic tap, tin, tin_q;

  always_comb begin
    tap = div[9];
    case (tap_sel_e'(tac[1:0]))
      TAP_4K:   tap = div[9];
      TAP_262K: tap = div[3];
      TAP_65K:  tap = div[5];
      TAP_16K:  tap = div[7];
      default:  tap = div[9];
    endcase
  end

  assign tin = tap & tac[2];

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) tin_q <= 1'b0;
    else         tin_q <= tin;

  // mask suppresses the edge caused purely by a TAC rewrite
  assign inc = tin_q & ~tin & ~mask;
endmodule

// File: rtl/dmg_timer.sv
// DMG timer: TIMA/TMA/TAC with delayed overflow reload and IRQ.
// Optional TIMER_GLITCH_EN: TAC writes that drop the timer input increment TIMA.
module dmg_timer
  import dmg_timer_pkg::*;
#(
  parameter int OVF_DELAY = 4
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [9:0]   div,
  dmg_timer_if.slave   bus,
  output logic         irq,
  input  logic         irq_ack
);
  localparam logic [1:0] OVF_LAST = 2'(OVF_DELAY - 2);

  logic [7:0] tima, tma;
  logic [2:0] tac;
  logic [1:0] cnt;
  state_e     state;
  logic       wr, rd, wr_tima, wr_tma, wr_tac, inc, mask;

  assign wr      = bus.sel & bus.cpu_wr & (bus.addr != 2'd0);
  assign rd      = bus.sel & bus.cpu_rd & (bus.addr != 2'd0);
  assign wr_tima = wr & (bus.addr == A_TIMA);
  assign wr_tma  = wr & (bus.addr == A_TMA);
  assign wr_tac  = wr & (bus.addr == A_TAC);

`ifdef TIMER_GLITCH_EN
  assign mask = 1'b0;
`else
  logic tac_wr_q;
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) tac_wr_q <= 1'b0;
    else         tac_wr_q <= wr_tac;
  assign mask = tac_wr_q;
`endif

  dmg_timer_tap u_tap (
    .clk(clk), .nreset(nreset), .div(div), .tac(tac), .mask(mask), .inc(inc)
  );

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tima  <= 8'h00;
      cnt   <= 2'd0;
      state <= RUN;
    end else begin
      case (state)
        RUN:
          if (wr_tima) tima <= bus.d_in;
          else if (inc) begin
            tima <= tima + 8'd1;
            if (tima == 8'hFF) begin
              state <= OVF;
              cnt   <= 2'd0;
            end
          end
        OVF:
          if (wr_tima) begin
            tima  <= bus.d_in;
            state <= RUN;
          end else begin
            if (inc) tima <= tima + 8'd1;
            cnt <= cnt + 2'd1;
            if (cnt == OVF_LAST) state <= RELOAD;
          end
        RELOAD: begin
          // a TMA write landing in this cycle is what reaches TIMA
          tima  <= wr_tma ? bus.d_in : tma;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tma <= 8'h00;
      tac <= 3'b000;
      irq <= 1'b0;
    end else begin
      if (wr_tma) tma <= bus.d_in;
      if (wr_tac) tac <= bus.d_in[2:0];
      if (state == RELOAD) irq <= 1'b1;
      else if (irq_ack)    irq <= 1'b0;
    end
  end

  always_comb begin
    bus.d_out = 8'h00;
    if (rd)
      case (bus.addr)
        A_TIMA:  bus.d_out = tima;
        A_TMA:   bus.d_out = tma;
        A_TAC:   bus.d_out = {5'b11111, tac};
        default: bus.d_out = 8'h00;
      endcase
  end

  assign bus.d_oe = rd;
endmodule

// File: tb/tb_dmg_timer.sv
// Self-checking bench for dmg_timer: reset table, directed corner sequences, random vs model.
module tb_dmg_timer;
  localparam int OVF_DELAY = 4;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [9:0] div_r = 10'd0;
  logic       div_clr = 1'b0;
  logic       irq;
  logic       irq_ack = 1'b0;
  logic       mon_en = 1'b0;
  int         total = 0;
  int         bad = 0;

  dmg_timer_if bus();

  dmg_timer #(.OVF_DELAY(OVF_DELAY)) dut (
    .clk(clk), .nreset(nreset), .div(div_r), .bus(bus), .irq(irq), .irq_ack(irq_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) div_r <= div_clr ? 10'd0 : div_r + 10'd1;

  // Reference model: register values plus a countdown to the pending reload
  typedef struct {
    int tima, tma, tac, irq, tin_q, tacw, left;
  } model_t;
  model_t m;

  function automatic int tap_bit(int t);
    case (t & 3)
      0: return 9;
      1: return 3;
      2: return 5;
      default: return 7;
    endcase
  endfunction

  function automatic model_t step(model_t s, logic [9:0] dv, logic sel, logic w,
                                  logic [1:0] a, logic [7:0] d, logic ack);
    model_t n = s;
    int tin, fall;
    logic wv;
    wv   = sel && w && (a != 2'd0);
    tin  = ((s.tac >> 2) & 1) && dv[tap_bit(s.tac)];
    fall = s.tin_q && !tin;
`ifndef TIMER_GLITCH_EN
    if (s.tacw) fall = 0;
`endif
    if (s.left == 1) begin
      n.tima = (wv && a == 2'd2) ? int'(d) : s.tma;
      n.irq  = 1;
      n.left = 0;
    end else begin
      if (s.left > 1) n.left = s.left - 1;
      if (ack) n.irq = 0;
      if (wv && a == 2'd1) begin
        n.tima = d;
        n.left = 0;
      end else if (fall) begin
        if (s.tima == 255 && s.left == 0) begin
          n.tima = 0;
          n.left = OVF_DELAY;
        end else n.tima = (s.tima + 1) % 256;
      end
    end
    if (wv && a == 2'd2) n.tma = d;
    if (wv && a == 2'd3) n.tac = d & 7;
    n.tin_q = tin;
    n.tacw  = wv && a == 2'd3;
    return n;
  endfunction

  always @(posedge clk or negedge nreset)
    if (!nreset) m <= '{0, 0, 0, 0, 0, 0, 0};
    else m <= step(m, div_r, bus.sel, bus.cpu_wr, bus.addr, bus.d_in, irq_ack);

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_dout();
    if (!(bus.sel && bus.cpu_rd && bus.addr != 2'd0)) return 0;
    case (bus.addr)
      2'd1: return m.tima;
      2'd2: return m.tma;
      default: return 32'hF8 | m.tac;
    endcase
  endfunction

  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      chk("mon_dout", int'(bus.d_out), exp_dout());
      chk("mon_oe", int'(bus.d_oe), int'(bus.sel && bus.cpu_rd && bus.addr != 2'd0));
      chk("mon_irq", int'(irq), m.irq);
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.cpu_wr = 1'b1; bus.addr = a; bus.d_in = d;
    @(negedge clk);
    bus.cpu_wr = 1'b0;
  endtask

  task automatic rd_is(input string nm, input logic [1:0] a, input int exp);
    bus.sel = 1'b1; bus.cpu_rd = 1'b1; bus.addr = a;
    #1;
    chk(nm, int'(bus.d_out), exp);
  endtask

  task automatic ack_irq();
    @(negedge clk); irq_ack = 1'b1;
    @(negedge clk); irq_ack = 1'b0;
  endtask

  // TAC=5 written on the same edge that clears div; returns at the negedge after that edge
  task automatic start_tac5();
    @(negedge clk);
    bus.sel = 1'b1; bus.cpu_wr = 1'b1; bus.addr = 2'd3; bus.d_in = 8'h05; div_clr = 1'b1;
    @(negedge clk);
    bus.cpu_wr = 1'b0; div_clr = 1'b0;
  endtask

  // returns at the negedge just after the wrap edge N
  task automatic setup_wrap(input logic [7:0] tma_v);
    wr(2'd3, 8'h00); wr(2'd2, tma_v); wr(2'd1, 8'hFF);
    start_tac5();
    repeat (17) @(negedge clk);
  endtask

  typedef struct {
    logic sel, rd;
    logic [1:0] addr;
    logic [7:0] exp_d;
    logic exp_oe;
  } vec_t;
  vec_t tv[6];

  initial begin
    bus.sel = 1'b0; bus.addr = 2'd0; bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.d_in = 8'h00;
    tv[0] = '{1'b1, 1'b1, 2'd1, 8'h00, 1'b1};
    tv[1] = '{1'b1, 1'b1, 2'd2, 8'h00, 1'b1};
    tv[2] = '{1'b1, 1'b1, 2'd3, 8'hF8, 1'b1};
    tv[3] = '{1'b1, 1'b1, 2'd0, 8'h00, 1'b0};
    tv[4] = '{1'b0, 1'b1, 2'd1, 8'h00, 1'b0};
    tv[5] = '{1'b1, 1'b0, 2'd3, 8'h00, 1'b0};
    repeat (3) @(negedge clk);
    chk("rst_irq", int'(irq), 0);
    chk("rst_oe", int'(bus.d_oe), 0);
    nreset = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.sel = tv[i].sel; bus.cpu_rd = tv[i].rd; bus.addr = tv[i].addr;
      #1;
      chk($sformatf("rst_vec%0d_d", i), int'(bus.d_out), int'(tv[i].exp_d));
      chk($sformatf("rst_vec%0d_oe", i), int'(bus.d_oe), int'(tv[i].exp_oe));
    end

    // 262 kHz tap: first increment on the edge after div[3] first falls
    wr(2'd1, 8'h00);
    start_tac5();
    repeat (16) @(negedge clk);
    rd_is("inc_before", 2'd1, 0);
    @(negedge clk); rd_is("inc_first", 2'd1, 1);
    repeat (15) @(negedge clk); rd_is("inc_hold", 2'd1, 1);
    @(negedge clk); rd_is("inc_second", 2'd1, 2);

    // wrap, delayed reload and sticky irq
    setup_wrap(8'hFE);
    rd_is("wrap_zero", 2'd1, 0);
    chk("wrap_irq0", int'(irq), 0);
    repeat (3) @(negedge clk);
    rd_is("wrap_zero_last", 2'd1, 0);
    chk("wrap_irq_pre", int'(irq), 0);
    @(negedge clk);
    rd_is("wrap_reload", 2'd1, 8'hFE);
    chk("wrap_irq1", int'(irq), 1);
    repeat (5) @(negedge clk);
    chk("irq_sticky", int'(irq), 1);
    ack_irq();
    chk("irq_acked", int'(irq), 0);

    // TIMA write during OVF cancels reload and irq
    setup_wrap(8'hFE);
    bus.cpu_wr = 1'b1; bus.addr = 2'd1; bus.d_in = 8'h42;
    @(negedge clk); bus.cpu_wr = 1'b0;
    @(negedge clk); rd_is("ovf_wr", 2'd1, 8'h42);
    repeat (4) @(negedge clk);
    rd_is("ovf_wr_hold", 2'd1, 8'h42);
    chk("ovf_wr_noirq", int'(irq), 0);

    // TMA write in RELOAD reaches TIMA
    setup_wrap(8'hFE);
    repeat (3) @(negedge clk);
    bus.cpu_wr = 1'b1; bus.addr = 2'd2; bus.d_in = 8'h10;
    @(negedge clk); bus.cpu_wr = 1'b0;
    rd_is("rld_tma", 2'd1, 8'h10);
    chk("rld_tma_irq", int'(irq), 1);
    ack_irq();

    // TIMA write in RELOAD is ignored
    setup_wrap(8'hFE);
    repeat (3) @(negedge clk);
    bus.cpu_wr = 1'b1; bus.addr = 2'd1; bus.d_in = 8'h77;
    @(negedge clk); bus.cpu_wr = 1'b0;
    rd_is("rld_tima", 2'd1, 8'hFE);
    chk("rld_tima_irq", int'(irq), 1);
    ack_irq();

    // TAC rewrite while the tap is high
    wr(2'd3, 8'h00); wr(2'd1, 8'h30);
    start_tac5();
    repeat (9) @(negedge clk);
    bus.cpu_wr = 1'b1; bus.addr = 2'd3; bus.d_in = 8'h01;
    @(negedge clk); bus.cpu_wr = 1'b0;
    repeat (3) @(negedge clk);
`ifdef TIMER_GLITCH_EN
    rd_is("tac_glitch", 2'd1, 8'h31);
`else
    rd_is("tac_glitch", 2'd1, 8'h30);
`endif

    // FF04 clear dropping a high tap increments in both builds
    wr(2'd3, 8'h00); wr(2'd1, 8'h50);
    start_tac5();
    repeat (9) @(negedge clk);
    div_clr = 1'b1;
    @(negedge clk); div_clr = 1'b0;
    repeat (3) @(negedge clk);
    rd_is("div_clr_inc", 2'd1, 8'h51);

    // reset during OVF aborts the reload
    setup_wrap(8'hFE);
    @(negedge clk);
    nreset = 1'b0;
    #1 chk("mid_rst_irq", int'(irq), 0);
    @(negedge clk); nreset = 1'b1;
    repeat (6) @(negedge clk);
    chk("mid_rst_noirq", int'(irq), 0);
    rd_is("mid_rst_tima", 2'd1, 0);
    rd_is("mid_rst_tma", 2'd2, 0);

    // random traffic against the model
    repeat (6000) begin
      @(negedge clk);
      bus.sel    = ($urandom_range(0, 7) != 0);
      bus.cpu_wr = ($urandom_range(0, 5) == 0);
      bus.cpu_rd = ($urandom_range(0, 1) == 1);
      bus.addr   = 2'($urandom_range(0, 3));
      bus.d_in   = 8'($urandom);
      if (bus.addr == 2'd1 && $urandom_range(0, 1) == 1) bus.d_in = 8'($urandom_range(8'hF0, 8'hFF));
      if (bus.addr == 2'd3 && $urandom_range(0, 3) != 0) bus.d_in[2] = 1'b1;
      div_clr = ($urandom_range(0, 63) == 0);
      irq_ack = ($urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; div_clr = 1'b0; irq_ack = 1'b0;
    @(negedge clk);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
